// File: rtl/simple_send_pkg.sv
// simple_send_pkg: shared timing defaults, FSM state encoding, command
// encoding and the colour scaling helper for the WS2812B simple_send driver.
package simple_send_pkg;

  // Default WS2812B timing at 100 MHz
  localparam int CLK_PER_BIT_DEF  = 128;
  localparam int T0H_DEF          = 40;
  localparam int T1H_DEF          = 80;
  localparam int RESET_CYCLES_DEF = 28100;

  // Brightness shift range and power-up value
  localparam int BRIGHT_INIT_DEF  = 2;
  localparam int BRIGHT_MAX       = 4;

  // One GRB word per LED module
  localparam int BITS_PER_LED     = 24;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RST  = 2'd1,
    DATA = 2'd2
  } state_t;

  // Decoded button command after priority resolution
  typedef enum logic [1:0] {
    CMD_NONE = 2'd0,
    CMD_GO   = 2'd1,
    CMD_UP   = 2'd2,
    CMD_DOWN = 2'd3
  } cmd_t;

  // A 4-bit nibble shifted left by the brightness; at shift 4 the nibble
  // lands in the top half of the byte, so nothing is ever lost.
  function automatic logic [7:0] scaleNibble(input logic [3:0] nib,
                                             input logic [2:0] shift);
    scaleNibble = {4'b0000, nib} << shift;
  endfunction

endpackage

// File: rtl/ws2812_bit_tx.sv
// ws2812_bit_tx: produces one WS2812B bit waveform per start pulse.
// The line is high for T1H (bit=1) or T0H (bit=0) clocks, then low until
// CLK_PER_BIT clocks have elapsed. o_bitDone is high in the last clock of
// the period; a start in that same clock chains the next bit seamlessly.
module ws2812_bit_tx
  import simple_send_pkg::*;
#(
  parameter int CLK_PER_BIT = CLK_PER_BIT_DEF,
  parameter int T0H         = T0H_DEF,
  parameter int T1H         = T1H_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic i_start,
  input  logic i_bit,
  output logic o_data,
  output logic o_bitDone
);

  localparam logic [6:0] CNT_LAST = 7'(CLK_PER_BIT - 1);
  localparam logic [6:0] HIGH_ONE = 7'(T1H);
  localparam logic [6:0] HIGH_ZERO = 7'(T0H);

  logic       r_busy;
  logic [6:0] r_cnt;
  logic       r_bit;
  logic       r_data;

  logic [6:0] w_cntNext;
  logic [6:0] w_highLen;

  assign w_cntNext = r_cnt + 7'd1;
  assign w_highLen = r_bit ? HIGH_ONE : HIGH_ZERO;
  assign o_bitDone = r_busy && (r_cnt == CNT_LAST);
  assign o_data    = r_data;

  // Bit-period counter and registered line level
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_busy <= 1'b0;
      r_cnt  <= 7'd0;
      r_bit  <= 1'b0;
      r_data <= 1'b0;
    end else if (i_start) begin
      r_busy <= 1'b1;
      r_cnt  <= 7'd0;
      r_bit  <= i_bit;
      r_data <= 1'b1;
    end else if (o_bitDone) begin
      r_busy <= 1'b0;
      r_cnt  <= 7'd0;
      r_data <= 1'b0;
    end else if (r_busy) begin
      r_cnt  <= w_cntNext;
      r_data <= (w_cntNext < w_highLen);
    end
  end

endmodule

// File: rtl/simple_send.sv
// simple_send: minimal WS2812B driver sending one 24-bit GRB colour to
// 1..7 chained modules. Colour nibbles come from sw, brightness shift is
// stepped by Up/Down, Go sends with the current brightness.
// Optional build macro SIMPLE_SEND_DEBOUNCE_EN: when defined, each
// synchronised button must be stable for 4 clocks before its level is used.
module simple_send
  import simple_send_pkg::*;
#(
  parameter int CLK_PER_BIT  = CLK_PER_BIT_DEF,
  parameter int T0H          = T0H_DEF,
  parameter int T1H          = T1H_DEF,
  parameter int RESET_CYCLES = RESET_CYCLES_DEF,
  parameter int BRIGHT_INIT  = BRIGHT_INIT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  output logic        dataOut,
  input  logic [15:4] sw,
  input  logic [3:1]  NumLEDs,
  input  logic        Go,
  input  logic        Up,
  input  logic        Down,
  output logic        Ready2Go
);

  localparam int RST_W = $clog2(RESET_CYCLES + 1);
  localparam logic [RST_W-1:0] RST_LAST = RST_W'(RESET_CYCLES - 1);
  localparam logic [4:0] LAST_BIT = 5'(BITS_PER_LED - 1);
  localparam logic [2:0] BRIGHT_MAX_B = 3'(BRIGHT_MAX);
  localparam logic [2:0] BRIGHT_INIT_B = 3'(BRIGHT_INIT);

  // Button path: {Go, Up, Down} in bits [2:0]
  logic [2:0] w_btnRaw;
  logic [2:0] r_sync1;
  logic [2:0] r_sync2;
  logic [2:0] w_level;
  logic [2:0] r_levelD;
  logic [2:0] w_rise;
  cmd_t       w_cmd;

  // Frame state
  state_t           r_state;
  state_t           w_stateNext;
  logic [RST_W-1:0] r_rstCnt;
  logic [4:0]       r_bitIdx;
  logic [2:0]       r_modIdx;
  logic [2:0]       r_numLeds;
  logic [23:0]      r_word;
  logic [2:0]       r_bright;
  logic [2:0]       w_newBright;

  // FSM control
  logic       w_accept;
  logic       w_txStart;
  logic       w_txBit;
  logic       w_advance;
  logic       w_bitDone;
  logic       w_lastBit;
  logic [4:0] w_nextIdx;

  assign w_btnRaw = {Go, Up, Down};

  // Two-flop synchroniser for the asynchronous buttons
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= 3'b000;
      r_sync2 <= 3'b000;
    end else begin
      r_sync1 <= w_btnRaw;
      r_sync2 <= r_sync1;
    end
  end

`ifdef SIMPLE_SEND_DEBOUNCE_EN
  logic [2:0] r_stable;
  logic [1:0] r_dbCnt [0:2];

  // Accept a new button level only after 4 consecutive differing samples
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stable <= 3'b000;
      for (int i = 0; i < 3; i++) begin
        r_dbCnt[i] <= 2'd0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (r_sync2[i] == r_stable[i]) begin
          r_dbCnt[i] <= 2'd0;
        end else if (r_dbCnt[i] == 2'd3) begin
          r_stable[i] <= r_sync2[i];
          r_dbCnt[i]  <= 2'd0;
        end else begin
          r_dbCnt[i] <= r_dbCnt[i] + 2'd1;
        end
      end
    end
  end

  assign w_level = r_stable;
`else
  assign w_level = r_sync2;
`endif

  // Previous level for rising-edge detection; runs even while busy so a
  // press during a frame is consumed and never replayed later
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_levelD <= 3'b000;
    end else begin
      r_levelD <= w_level;
    end
  end

  assign w_rise = w_level & ~r_levelD;

  // Resolve simultaneous edges: Go beats Up beats Down
  always_comb begin
    w_cmd = CMD_NONE;
    if (w_rise[2]) begin
      w_cmd = CMD_GO;
    end else if (w_rise[1]) begin
      w_cmd = CMD_UP;
    end else if (w_rise[0]) begin
      w_cmd = CMD_DOWN;
    end
  end

  // Saturating brightness step applied when the command is accepted
  always_comb begin
    w_newBright = r_bright;
    case (w_cmd)
      CMD_UP: begin
        if (r_bright < BRIGHT_MAX_B) begin
          w_newBright = r_bright + 3'd1;
        end
      end
      CMD_DOWN: begin
        if (r_bright != 3'd0) begin
          w_newBright = r_bright - 3'd1;
        end
      end
      default: begin
      end
    endcase
  end

  assign w_nextIdx = (r_bitIdx == LAST_BIT) ? 5'd0 : (r_bitIdx + 5'd1);
  assign w_lastBit = (r_bitIdx == LAST_BIT) && (r_modIdx == (r_numLeds - 3'd1));

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next-state and bit transmitter control
  always_comb begin
    w_stateNext = r_state;
    w_accept    = 1'b0;
    w_txStart   = 1'b0;
    w_txBit     = 1'b0;
    w_advance   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_cmd != CMD_NONE) begin
          w_accept    = 1'b1;
          w_stateNext = RST;
        end
      end
      RST: begin
        if (r_rstCnt == RST_LAST) begin
          if (r_numLeds == 3'd0) begin
            w_stateNext = IDLE;
          end else begin
            w_stateNext = DATA;
            w_txStart   = 1'b1;
            w_txBit     = r_word[LAST_BIT];
          end
        end
      end
      DATA: begin
        if (w_bitDone) begin
          if (w_lastBit) begin
            w_stateNext = IDLE;
          end else begin
            w_txStart = 1'b1;
            w_txBit   = r_word[LAST_BIT - w_nextIdx];
            w_advance = 1'b1;
          end
        end
      end
      default: begin
        w_stateNext = IDLE;
      end
    endcase
  end

  // Frame latches, brightness and the reset/bit/module counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rstCnt  <= '0;
      r_bitIdx  <= 5'd0;
      r_modIdx  <= 3'd0;
      r_numLeds <= 3'd0;
      r_word    <= 24'd0;
      r_bright  <= BRIGHT_INIT_B;
    end else if (w_accept) begin
      r_rstCnt  <= '0;
      r_bitIdx  <= 5'd0;
      r_modIdx  <= 3'd0;
      r_numLeds <= NumLEDs;
      r_bright  <= w_newBright;
      r_word    <= {scaleNibble(sw[15:12], w_newBright),
                    scaleNibble(sw[11:8],  w_newBright),
                    scaleNibble(sw[7:4],   w_newBright)};
    end else begin
      if ((r_state == RST) && (r_rstCnt != RST_LAST)) begin
        r_rstCnt <= r_rstCnt + 1'b1;
      end
      if (w_advance) begin
        if (r_bitIdx == LAST_BIT) begin
          r_bitIdx <= 5'd0;
          r_modIdx <= r_modIdx + 3'd1;
        end else begin
          r_bitIdx <= r_bitIdx + 5'd1;
        end
      end
    end
  end

  ws2812_bit_tx #(
    .CLK_PER_BIT (CLK_PER_BIT),
    .T0H         (T0H),
    .T1H         (T1H)
  ) u_bitTx (
    .clk       (clk),
    .reset     (reset),
    .i_start   (w_txStart),
    .i_bit     (w_txBit),
    .o_data    (dataOut),
    .o_bitDone (w_bitDone)
  );

  assign Ready2Go = (r_state == IDLE);

endmodule

// File: tb/tb_simple_send.sv
// tb_simple_send: randomized scoreboard bench for simple_send. Commands push
// an expected frame (module count and GRB word) into a queue; a monitor
// decodes the dataOut waveform and compares each completed frame.
// Timing parameters are shrunk so many frames fit in a short run.
module tb_simple_send;

  localparam int CPB = 16;
  localparam int T0  = 5;
  localparam int T1  = 11;
  localparam int RC  = 40;
  localparam int BI  = 2;
`ifdef SIMPLE_SEND_DEBOUNCE_EN
  localparam int LAT = 8;
`else
  localparam int LAT = 4;
`endif
  localparam int IDLE_LIMIT = RC + 7 * 24 * CPB + 50;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        dataOut;
  logic [15:4] sw = 12'h000;
  logic [3:1]  NumLEDs = 3'd0;
  logic        Go = 1'b0;
  logic        Up = 1'b0;
  logic        Down = 1'b0;
  logic        Ready2Go;

  typedef struct {
    int          n;
    logic [23:0] word;
  } frame_t;

  frame_t expQ[$];
  int     nChecks = 0;
  int     nFails = 0;
  int     mBright = BI;

  simple_send #(
    .CLK_PER_BIT  (CPB),
    .T0H          (T0),
    .T1H          (T1),
    .RESET_CYCLES (RC),
    .BRIGHT_INIT  (BI)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .dataOut  (dataOut),
    .sw       (sw),
    .NumLEDs  (NumLEDs),
    .Go       (Go),
    .Up       (Up),
    .Down     (Down),
    .Ready2Go (Ready2Go)
  );

  always #5 clk = ~clk;

  // Abort if the run stalls
  initial begin
    #900000;
    $display("[TB] FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input longint act, input longint exp);
    nChecks++;
    if (act != exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Reference colour: each nibble times 2^brightness
  function automatic logic [23:0] modelWord(input logic [11:0] s, input int b);
    int g;
    int r;
    int bl;
    g  = int'(s[11:8]) * (2 ** b);
    r  = int'(s[7:4])  * (2 ** b);
    bl = int'(s[3:0])  * (2 ** b);
    return {8'(g), 8'(r), 8'(bl)};
  endfunction

  task automatic pressButtons(input logic [2:0] b, input int width);
    @(negedge clk);
    {Go, Up, Down} = b;
    repeat (width) @(negedge clk);
    {Go, Up, Down} = 3'b000;
  endtask

  task automatic waitIdle();
    int c;
    c = 0;
    while (!Ready2Go && c < IDLE_LIMIT) begin
      @(negedge clk);
      c++;
    end
    checkOutput("frame_done_in_time", Ready2Go, 1);
    repeat (4) @(negedge clk);
  endtask

  // Issue a command while idle, updating the model and expected queue
  task automatic applyStimulus(input logic [2:0] b, input logic [11:0] s, input int n);
    int k;
    sw = s;
    NumLEDs = 3'(n);
    if (b[2]) begin
    end else if (b[1]) begin
      mBright = (mBright + 1 > 4) ? 4 : mBright + 1;
    end else if (b[0]) begin
      mBright = (mBright - 1 < 0) ? 0 : mBright - 1;
    end
    expQ.push_back('{n: n, word: modelWord(s, mBright)});
    @(negedge clk);
    {Go, Up, Down} = b;
    k = 0;
    while (Ready2Go && k < LAT + 4) begin
      @(negedge clk);
      k++;
    end
    checkOutput("cmd_latency_within_limit", (k <= LAT), 1);
    if (k < 8) repeat (8 - k) @(negedge clk);
    {Go, Up, Down} = 3'b000;
    waitIdle();
  endtask

  // Monitor: decode dataOut into bits and check each finished frame
  logic mInFrame = 1'b0;
  logic mPrevD = 1'b0;
  int   mCyc = 0;
  int   mHigh = 0;
  int   mLastRise = -1;
  bit   mBits[$];

  always @(negedge clk) begin
    frame_t e;
    logic [23:0] w;
    if (!reset) begin
      mInFrame = 1'b0;
      mPrevD = 1'b0;
    end else begin
      if (!mInFrame && !Ready2Go) begin
        mInFrame = 1'b1;
        mCyc = 0;
        mHigh = 0;
        mLastRise = -1;
        mBits.delete();
      end
      if (mInFrame) begin
        if (Ready2Go) begin
          mInFrame = 1'b0;
          checkOutput("frame_expected", (expQ.size() > 0), 1);
          if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput("bit_count", mBits.size(), e.n * 24);
            checkOutput("frame_len", mCyc, RC + e.n * 24 * CPB);
            if (mBits.size() == e.n * 24) begin
              for (int m = 0; m < e.n; m++) begin
                w = 24'd0;
                for (int k = 0; k < 24; k++) begin
                  w = {w[22:0], mBits[m * 24 + k]};
                end
                checkOutput($sformatf("word_led%0d", m), w, e.word);
              end
            end
          end
        end else begin
          if (dataOut && !mPrevD) begin
            if (mLastRise < 0) begin
              checkOutput("lead_low_len", mCyc, RC);
            end else begin
              checkOutput("bit_period", mCyc - mLastRise, CPB);
            end
            mLastRise = mCyc;
            mHigh = 1;
          end else if (dataOut) begin
            mHigh++;
          end
          if (!dataOut && mPrevD) begin
            nChecks++;
            if (mHigh == T1) begin
              mBits.push_back(1'b1);
            end else if (mHigh == T0) begin
              mBits.push_back(1'b0);
            end else begin
              nFails++;
              $display("[TB] FAIL pulse_width: got %0d, expected %0d or %0d", mHigh, T0, T1);
            end
          end
          mCyc++;
        end
      end
      mPrevD = dataOut;
    end
  end

  initial begin
    int k;
    logic [11:0] swr;
    $display("[TB] start");
    repeat (5) @(negedge clk);
    reset = 1'b1;

    // Idle after reset with no buttons
    for (int i = 0; i < 5; i++) begin
      repeat (4) @(negedge clk);
      checkOutput("idle_dataOut", dataOut, 0);
      checkOutput("idle_ready", Ready2Go, 1);
    end

    // Full brightness-2 white, one module: 3C per channel
    applyStimulus(3'b100, 12'hFFF, 1);
    // Five modules of 10/28/24
    applyStimulus(3'b100, 12'h4A9, 5);
    // Up to 3, then saturate at 4, then back down to 3
    applyStimulus(3'b010, 12'h400, 1);
    applyStimulus(3'b010, 12'h400, 1);
    applyStimulus(3'b010, 12'h400, 1);
    applyStimulus(3'b010, 12'h400, 1);
    applyStimulus(3'b001, 12'h400, 1);
    // Zero modules: only the latch period
    applyStimulus(3'b100, 12'h123, 0);

    // Presses and sw changes mid-frame are ignored
    sw = 12'h4A9;
    NumLEDs = 3'd2;
    expQ.push_back('{n: 2, word: modelWord(12'h4A9, mBright)});
    pressButtons(3'b100, 8);
    repeat (RC + 200) @(negedge clk);
    sw = 12'h123;
    NumLEDs = 3'd7;
    pressButtons(3'b100, 8);
    repeat (50) @(negedge clk);
    pressButtons(3'b010, 8);
    waitIdle();
    applyStimulus(3'b100, 12'h123, 1);

    // Short 2-clock pulse
`ifdef SIMPLE_SEND_DEBOUNCE_EN
    pressButtons(3'b100, 2);
    k = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (!Ready2Go) k++;
    end
    checkOutput("short_pulse_ignored", k, 0);
`else
    sw = 12'h5C3;
    NumLEDs = 3'd1;
    expQ.push_back('{n: 1, word: modelWord(12'h5C3, mBright)});
    pressButtons(3'b100, 2);
    repeat (6) @(negedge clk);
    checkOutput("short_pulse_accepted", Ready2Go, 0);
    waitIdle();
`endif

    // Randomized commands, including simultaneous presses
    for (int i = 0; i < 10; i++) begin
      swr = 12'($urandom);
      applyStimulus(3'($urandom_range(1, 7)), swr, $urandom_range(0, 4));
    end

    // Asynchronous reset while a data bit is high
    sw = 12'hFFF;
    NumLEDs = 3'd3;
    pressButtons(3'b100, 8);
    repeat (RC) @(negedge clk);
    k = 0;
    while (!dataOut && k < 200) begin
      @(negedge clk);
      k++;
    end
    checkOutput("data_high_before_reset", dataOut, 1);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("rst_mid_dataOut", dataOut, 0);
    checkOutput("rst_mid_ready", Ready2Go, 1);
    expQ.delete();
    mBright = BI;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    applyStimulus(3'b100, 12'hFFF, 1);

    repeat (10) @(negedge clk);
    checkOutput("pending_frames", expQ.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
